// File: rtl/fifo_read_ctrl_if.sv
// Read-side FIFO bus: write pointer in, RAM read port, and the output VALID/READY stream.
// master = read controller, slave = write controller / RAM / consumer.
interface fifo_read_ctrl_if #(
   parameter int DW = 8,
   parameter int AW = 4
);
   logic [AW:0]   WPTR;
   logic [AW:0]   RPTR;
   logic          REN;
   logic [AW-1:0] RADDR;
   logic [DW-1:0] RDATA;
   logic [DW-1:0] DOUT;
   logic          DVALID;
   logic          DREADY;
   logic          EMPTY;
   logic          ALEMPTY;
   logic [AW+1:0] LEVEL;

   modport master (
      input  WPTR, RDATA, DREADY,
      output RPTR, REN, RADDR, DOUT, DVALID, EMPTY, ALEMPTY, LEVEL
   );

   modport slave (
      output WPTR, RDATA, DREADY,
      input  RPTR, REN, RADDR, DOUT, DVALID, EMPTY, ALEMPTY, LEVEL
   );
endinterface

// File: rtl/fifo_read_ctrl.sv
// Read controller for the single-clock FIFO: pointer compare, sync-RAM read issue
// and a 2-entry output buffer (head + skid) behind a VALID/READY handshake.
//
//  state | meaning
//  ------+-----------------------------------------------
//  S0    | buffer empty, DVALID low
//  S1    | head holds one word
//  S2    | head and skid slot both hold a word
module fifo_read_ctrl #(
   parameter int DW       = 8,
   parameter int AW       = 4,
   parameter int AE_LEVEL = 2
) (
   input  logic             CK,
   input  logic             CLRN,
   fifo_read_ctrl_if.master bus
);

   localparam int LW = AW + 2;
   localparam logic [LW-1:0] AE_THR = LW'(AE_LEVEL);

   typedef enum logic [1:0] {
      S0 = 2'd0,
      S1 = 2'd1,
      S2 = 2'd2
   } occ_e;

   occ_e          state_q, state_d;
   logic [AW:0]   rptr_q, rptr_d;
   logic          infl_q, infl_d;
   logic [DW-1:0] head_q, head_d;
   logic [DW-1:0] skid_q, skid_d;

   logic          dvalid;
   logic          pop;
   logic          cap;
   logic          ram_empty;
   logic          ren;
   logic [1:0]    occ;
   logic [2:0]    pend;
   logic [AW:0]   ramcnt;
   logic [LW-1:0] level;

   assign dvalid    = (state_q != S0);
   assign pop       = dvalid & bus.DREADY;
   assign cap       = infl_q;
   assign ram_empty = (bus.WPTR == rptr_q);

   always_ff @(posedge CK or negedge CLRN) begin
      if (!CLRN) begin
         state_q <= S0;
         rptr_q  <= '0;
         infl_q  <= 1'b0;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         rptr_q  <= rptr_d;
         infl_q  <= infl_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

   // A capture in S2 cannot happen: the read-issue rule keeps OCC + INFL <= 2.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S0: if (cap) state_d = S1;
         S1: begin
            if (cap && !pop)      state_d = S2;
            else if (pop && !cap) state_d = S0;
         end
         S2: if (pop) state_d = S1;
         default: state_d = S0;
      endcase
   end

   always_comb begin
      head_d = head_q;
      skid_d = skid_q;
      occ    = 2'd0;
      case (state_q)
         S0: begin
            occ = 2'd0;
            if (cap) head_d = bus.RDATA;
         end
         S1: begin
            occ = 2'd1;
            if (cap && pop) head_d = bus.RDATA;
            else if (cap)   skid_d = bus.RDATA;
         end
         S2: begin
            occ = 2'd2;
            if (pop) head_d = skid_q;
         end
         default: occ = 2'd0;
      endcase

      // Issue a read only if the word will still have a buffer slot when it lands.
      pend   = {1'b0, occ} + {2'b00, infl_q};
      ren    = !ram_empty && (pend < (3'd2 + {2'b00, pop}));
      rptr_d = ren ? rptr_q + 1'b1 : rptr_q;
      infl_d = ren;

      ramcnt = bus.WPTR - rptr_q;
      level  = {1'b0, ramcnt} + LW'(infl_q) + LW'(occ);
   end

   assign bus.RPTR    = rptr_q;
   assign bus.RADDR   = rptr_q[AW-1:0];
   assign bus.REN     = ren;
   assign bus.DOUT    = head_q;
   assign bus.DVALID  = dvalid;
   assign bus.LEVEL   = level;
   assign bus.EMPTY   = (level == '0);
   assign bus.ALEMPTY = (level <= AE_THR);

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: directed scenarios plus a randomized run against a
// word-queue reference (LEVEL = words written - words popped).
module tb_fifo_read_ctrl;

   logic ck   = 1'b0;
   logic clrn = 1'b0;
   always #5 ck = ~ck;

   fifo_read_ctrl_if #(.DW(8), .AW(4)) bus ();

   fifo_read_ctrl #(.DW(8), .AW(4), .AE_LEVEL(2)) dut (
      .CK   (ck),
      .CLRN (clrn),
      .bus  (bus)
   );

   logic [7:0] mem [16];
   always @(posedge ck) if (bus.REN) bus.RDATA <= mem[bus.RADDR];

   int         total = 0;
   int         bad   = 0;
   int         written = 0;
   int         popped  = 0;
   logic [4:0] wp = '0;
   logic [7:0] expq [$];

   task automatic step();
      @(posedge ck);
      #1;
   endtask

   task automatic push(input int n, input logic [7:0] base);
      for (int i = 0; i < n; i++) begin
         mem[wp[3:0]] = 8'(base + 8'(i));
         expq.push_back(8'(base + 8'(i)));
         wp = wp + 5'd1;
         written++;
      end
      bus.WPTR = wp;
   endtask

   task automatic do_reset();
      clrn       = 1'b0;
      wp         = '0;
      bus.WPTR   = '0;
      bus.DREADY = 1'b0;
      expq.delete();
      written = 0;
      popped  = 0;
      step();
      step();
      clrn = 1'b1;
   endtask

   task automatic test_reset();
      bus.WPTR   = '0;
      bus.DREADY = 1'b0;
      #1;
      total++; if (bus.DVALID !== 1'b0) begin bad++; $display("FAIL por_dvalid got %0b want 0", bus.DVALID); end
      total++; if (bus.RPTR !== 5'd0)   begin bad++; $display("FAIL por_rptr got %0d want 0", bus.RPTR); end
      total++; if (bus.REN !== 1'b0)    begin bad++; $display("FAIL por_ren got %0b want 0", bus.REN); end
      total++; if (bus.EMPTY !== 1'b1 || bus.ALEMPTY !== 1'b1 || bus.LEVEL !== 6'd0)
         begin bad++; $display("FAIL por_flags got E=%0b AE=%0b L=%0d want 1 1 0", bus.EMPTY, bus.ALEMPTY, bus.LEVEL); end
      total++; if (bus.DOUT !== 8'h00)  begin bad++; $display("FAIL por_dout got %0h want 00", bus.DOUT); end
      step();
      clrn = 1'b1;
      push(8, 8'h10);
      step();
      step();
      total++; if (bus.DVALID !== 1'b1 || bus.RPTR !== 5'd2)
         begin bad++; $display("FAIL midstream got dv=%0b rptr=%0d want 1 2", bus.DVALID, bus.RPTR); end
      clrn     = 1'b0;
      wp       = '0;
      bus.WPTR = '0;
      #1;
      total++; if (bus.DVALID !== 1'b0) begin bad++; $display("FAIL rst_dvalid got %0b want 0", bus.DVALID); end
      total++; if (bus.RPTR !== 5'd0)   begin bad++; $display("FAIL rst_rptr got %0d want 0", bus.RPTR); end
      total++; if (bus.EMPTY !== 1'b1 || bus.LEVEL !== 6'd0)
         begin bad++; $display("FAIL rst_empty got E=%0b L=%0d want 1 0", bus.EMPTY, bus.LEVEL); end
      total++; if (bus.DOUT !== 8'h00)  begin bad++; $display("FAIL rst_dout got %0h want 00", bus.DOUT); end
      for (int c = 0; c < 3; c++) begin
         @(negedge ck);
         total++; if (bus.DOUT !== 8'h00 || bus.DVALID !== 1'b0)
            begin bad++; $display("FAIL rst_hold got dout=%0h dv=%0b want 00 0", bus.DOUT, bus.DVALID); end
      end
      step();
      do_reset();
   endtask

   task automatic test_single();
      do_reset();
      bus.DREADY = 1'b1;
      push(1, 8'hA5);
      @(negedge ck);
      total++; if (bus.REN !== 1'b1 || bus.RADDR !== 4'd0)
         begin bad++; $display("FAIL single_ren got ren=%0b raddr=%0d want 1 0", bus.REN, bus.RADDR); end
      total++; if (bus.DVALID !== 1'b0) begin bad++; $display("FAIL single_early got %0b want 0", bus.DVALID); end
      step();
      @(negedge ck);
      total++; if (bus.DVALID !== 1'b0 || bus.REN !== 1'b0)
         begin bad++; $display("FAIL single_c1 got dv=%0b ren=%0b want 0 0", bus.DVALID, bus.REN); end
      step();
      @(negedge ck);
      total++; if (bus.DVALID !== 1'b1 || bus.DOUT !== 8'hA5)
         begin bad++; $display("FAIL single_out got dv=%0b dout=%0h want 1 a5", bus.DVALID, bus.DOUT); end
      total++; if (bus.EMPTY !== 1'b0 || bus.LEVEL !== 6'd1)
         begin bad++; $display("FAIL single_lvl got E=%0b L=%0d want 0 1", bus.EMPTY, bus.LEVEL); end
      step();
      @(negedge ck);
      total++; if (bus.EMPTY !== 1'b1 || bus.DVALID !== 1'b0)
         begin bad++; $display("FAIL single_drain got E=%0b dv=%0b want 1 0", bus.EMPTY, bus.DVALID); end
      step();
   endtask

   task automatic test_stream();
      int cnt  = 0;
      bit seen = 0;
      do_reset();
      bus.DREADY = 1'b1;
      push(16, 8'h00);
      for (int c = 0; c < 40 && cnt < 16; c++) begin
         @(negedge ck);
         if (bus.DVALID) begin
            total++; if (bus.DOUT !== 8'(cnt))
               begin bad++; $display("FAIL stream_dout got %0h want %0h", bus.DOUT, 8'(cnt)); end
            cnt++;
            seen = 1;
         end else if (seen) begin
            total++; bad++; $display("FAIL stream_gap got dvalid=0 want 1 at word %0d", cnt);
         end
         step();
      end
      total++; if (cnt != 16) begin bad++; $display("FAIL stream_count got %0d want 16", cnt); end
      @(negedge ck);
      total++; if (bus.RPTR !== 5'b10000 || bus.EMPTY !== 1'b1)
         begin bad++; $display("FAIL stream_end got rptr=%0d E=%0b want 16 1", bus.RPTR, bus.EMPTY); end
      step();
   endtask

   task automatic test_backpressure();
      int cnt = 0;
      do_reset();
      bus.DREADY = 1'b0;
      push(8, 8'h40);
      repeat (4) step();
      @(negedge ck);
      total++; if (bus.REN !== 1'b0 || bus.RPTR !== 5'd2)
         begin bad++; $display("FAIL bp_stall got ren=%0b rptr=%0d want 0 2", bus.REN, bus.RPTR); end
      total++; if (bus.DVALID !== 1'b1 || bus.DOUT !== 8'h40 || bus.LEVEL !== 6'd8)
         begin bad++; $display("FAIL bp_head got dv=%0b dout=%0h L=%0d want 1 40 8", bus.DVALID, bus.DOUT, bus.LEVEL); end
      step();
      @(negedge ck);
      total++; if (bus.DOUT !== 8'h40 || bus.RPTR !== 5'd2)
         begin bad++; $display("FAIL bp_hold got dout=%0h rptr=%0d want 40 2", bus.DOUT, bus.RPTR); end
      step();
      bus.DREADY = 1'b1;
      for (int c = 0; c < 30 && cnt < 8; c++) begin
         @(negedge ck);
         if (bus.DVALID) begin
            total++; if (bus.DOUT !== 8'(8'h40 + 8'(cnt)))
               begin bad++; $display("FAIL bp_order got %0h want %0h", bus.DOUT, 8'(8'h40 + 8'(cnt))); end
            cnt++;
         end
         step();
      end
      total++; if (cnt != 8) begin bad++; $display("FAIL bp_count got %0d want 8", cnt); end
      @(negedge ck);
      total++; if (bus.EMPTY !== 1'b1 || bus.RPTR !== 5'd8)
         begin bad++; $display("FAIL bp_end got E=%0b rptr=%0d want 1 8", bus.EMPTY, bus.RPTR); end
      step();
   endtask

   task automatic test_wrap();
      logic [3:0] exp_addr [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
      logic [4:0] exp_rptr [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
      int  cnt = 0;
      int  rd  = 0;
      int  lvl;
      bit  done;
      do_reset();
      bus.DREADY = 1'b1;
      for (int b = 0; b < 2; b++) begin
         push(15, 8'h80);
         done = 0;
         for (int c = 0; c < 50 && !done; c++) begin
            @(negedge ck);
            if (bus.EMPTY === 1'b1 && c > 0) done = 1;
            step();
         end
         total++; if (!done) begin bad++; $display("FAIL wrap_drain got not-empty want empty, batch %0d", b); end
      end
      @(negedge ck);
      total++; if (bus.RPTR !== 5'd30 || bus.LEVEL !== 6'd0 || bus.ALEMPTY !== 1'b1)
         begin bad++; $display("FAIL wrap_start got rptr=%0d L=%0d AE=%0b want 30 0 1", bus.RPTR, bus.LEVEL, bus.ALEMPTY); end
      step();
      bus.DREADY = 1'b0;
      push(4, 8'hC0);
      for (int c = 0; c < 30 && cnt < 4; c++) begin
         @(negedge ck);
         lvl = 4 - cnt;
         total++; if (bus.LEVEL !== 6'(lvl) || bus.ALEMPTY !== (lvl <= 2))
            begin bad++; $display("FAIL wrap_level got L=%0d AE=%0b want %0d %0b", bus.LEVEL, bus.ALEMPTY, lvl, (lvl <= 2)); end
         if (bus.REN) begin
            total++;
            if (rd >= 4) begin bad++; $display("FAIL wrap_extra got read %0d want at most 4", rd + 1); end
            else if (bus.RADDR !== exp_addr[rd] || bus.RPTR !== exp_rptr[rd])
               begin bad++; $display("FAIL wrap_addr got raddr=%0d rptr=%0d want %0d %0d", bus.RADDR, bus.RPTR, exp_addr[rd], exp_rptr[rd]); end
            rd++;
         end
         if (bus.DVALID && bus.DREADY) begin
            total++; if (bus.DOUT !== 8'(8'hC0 + 8'(cnt)))
               begin bad++; $display("FAIL wrap_dout got %0h want %0h", bus.DOUT, 8'(8'hC0 + 8'(cnt))); end
            cnt++;
         end
         step();
         if (c == 2) bus.DREADY = 1'b1;
      end
      total++; if (cnt != 4 || rd != 4) begin bad++; $display("FAIL wrap_count got pops=%0d reads=%0d want 4 4", cnt, rd); end
      @(negedge ck);
      total++; if (bus.RPTR !== 5'd2 || bus.EMPTY !== 1'b1)
         begin bad++; $display("FAIL wrap_end got rptr=%0d E=%0b want 2 1", bus.RPTR, bus.EMPTY); end
      step();
   endtask

   task automatic test_random();
      logic       last_ren  = 1'b0;
      logic       prev_dv   = 1'b0;
      logic       prev_rdy  = 1'b0;
      logic [7:0] prev_dout = '0;
      logic [7:0] w;
      int lvl, ramcnt, occ, room, n;
      bit done;
      do_reset();
      for (int cy = 0; cy < 10000; cy++) begin
         if ((cy % 600) < 300) bus.DREADY = ($urandom_range(0, 3) != 0);
         else                  bus.DREADY = ($urandom_range(0, 3) == 0);
         room = 16 - (written - popped);
         if (room > 0 && $urandom_range(0, 2) == 0) begin
            n = int'($urandom_range(1, (room < 4) ? room : 4));
            push(n, 8'($urandom));
         end
         @(negedge ck);
         lvl    = written - popped;
         ramcnt = int'(5'(bus.WPTR - bus.RPTR));
         occ    = lvl - ramcnt - int'(last_ren);
         total++; if (bus.LEVEL !== 6'(lvl) || bus.EMPTY !== (lvl == 0) || bus.ALEMPTY !== (lvl <= 2))
            begin bad++; $display("FAIL rnd_level cy=%0d got L=%0d E=%0b AE=%0b want %0d", cy, bus.LEVEL, bus.EMPTY, bus.ALEMPTY, lvl); end
         total++; if (bus.RADDR !== bus.RPTR[3:0])
            begin bad++; $display("FAIL rnd_raddr cy=%0d got %0d want %0d", cy, bus.RADDR, bus.RPTR[3:0]); end
         total++; if (occ < 0 || occ > 2 || (occ == 2 && last_ren) || bus.DVALID !== (occ != 0))
            begin bad++; $display("FAIL rnd_occ cy=%0d got occ=%0d infl=%0b dv=%0b want occ 0..2 no cap in S2", cy, occ, last_ren, bus.DVALID); end
         if (prev_dv && !prev_rdy) begin
            total++; if (bus.DVALID !== 1'b1 || bus.DOUT !== prev_dout)
               begin bad++; $display("FAIL rnd_stable cy=%0d got dv=%0b dout=%0h want 1 %0h", cy, bus.DVALID, bus.DOUT, prev_dout); end
         end
         if (bus.DVALID && bus.DREADY) begin
            total++;
            if (expq.size() == 0) begin bad++; $display("FAIL rnd_underrun cy=%0d got pop want none", cy); end
            else begin
               w = expq.pop_front();
               if (bus.DOUT !== w) begin bad++; $display("FAIL rnd_dout cy=%0d got %0h want %0h", cy, bus.DOUT, w); end
            end
            popped++;
         end
         last_ren  = bus.REN;
         prev_dv   = bus.DVALID;
         prev_rdy  = bus.DREADY;
         prev_dout = bus.DOUT;
         step();
      end
      bus.DREADY = 1'b1;
      done = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge ck);
         if (bus.EMPTY === 1'b1) done = 1;
         else if (bus.DVALID) begin
            total++;
            if (expq.size() == 0) begin bad++; $display("FAIL rnd_tail got extra word %0h want none", bus.DOUT); end
            else begin
               w = expq.pop_front();
               if (bus.DOUT !== w) begin bad++; $display("FAIL rnd_tail got %0h want %0h", bus.DOUT, w); end
            end
            popped++;
         end
         step();
      end
      total++; if (!done || expq.size() != 0)
         begin bad++; $display("FAIL rnd_final got empty=%0b left=%0d want 1 0", done, expq.size()); end
   endtask

   initial begin
      bus.WPTR   = '0;
      bus.DREADY = 1'b0;
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
